// File: rtl/icache_fifo_drain_if.sv
// Handshake bundle between the icache fetch FIFO, the drain stage and decode.
// The slave view is the drain stage. The master view is whoever drives the FIFO head and decode ready.
interface icache_fifo_drain_if #(
  parameter int FIFOWIDE = 68
);
  logic [FIFOWIDE-1:0] FifoPreOut;
  logic [2:0]          FifoPrePtr;
  logic                FifoEmpty;
  logic                Rable;
  logic                FifoClean;
  logic                Flush;
  logic                DecValid;
  logic                DecReady;
  logic [31:0]         DecPc;
  logic [31:0]         DecInst;
  logic [1:0]          DecExcp;
  logic                DecPredTaken;
  logic                HeadStall;
  logic [2:0]          HeadPtr;

  modport master (
    output FifoPreOut, FifoPrePtr, FifoEmpty, Flush, DecReady,
    input  Rable, FifoClean, DecValid, DecPc, DecInst, DecExcp, DecPredTaken,
           HeadStall, HeadPtr
  );

  modport slave (
    input  FifoPreOut, FifoPrePtr, FifoEmpty, Flush, DecReady,
    output Rable, FifoClean, DecValid, DecPc, DecInst, DecExcp, DecPredTaken,
           HeadStall, HeadPtr
  );
endinterface

// File: rtl/icache_fifo_drain.sv
// icache_fifo_drain: pops resolved entries off the icache fetch FIFO head and
// registers them toward decode. Cancelled entries are dropped. Heads that stay
// pending too long raise HeadStall. A redirect clears the FIFO.
// Optional feature macro: ICFD_PERF_EN (adds performance counter ports).
//
// state   | meaning
// S_IDLE  | FIFO empty, nothing to inspect
// S_WAIT  | head entry pending, stall timer counting
// S_RUN   | head resolved, entries flowing to decode
// S_FLUSH | one-cycle FIFO clear after a redirect
module icache_fifo_drain #(
  parameter int FIFOWIDE    = 68,
  parameter int STALL_LIMIT = 64
) (
  input  logic                Clk,
  input  logic                Rest,
  icache_fifo_drain_if.slave  bus
`ifdef ICFD_PERF_EN
  ,
  output logic [31:0]         PerfPopCnt,
  output logic [31:0]         PerfCancelCnt,
  output logic [31:0]         PerfStallCyc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_FLUSH} state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t      state, state_nxt;
  logic [1:0]  head_st;
  logic        head_resolved, head_cancel;
  logic        pop, load;
  logic [7:0]  wait_cnt;
  logic [2:0]  head_ptr;
  logic        dec_valid;
  logic [31:0] dec_pc, dec_inst;
  logic [1:0]  dec_excp;
  logic        dec_pred;

  assign head_st       = bus.FifoPreOut[3:2];
  assign head_resolved = (head_st != 2'b00);
  assign head_cancel   = (head_st == 2'b11);

  // State register.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and pop decision; Rest gates pop so it drops the moment reset asserts.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:  if (!bus.FifoEmpty) state_nxt = head_resolved ? S_RUN : S_WAIT;
      S_WAIT:  if (head_resolved) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.FifoEmpty)       state_nxt = S_IDLE;
        else if (!head_resolved) state_nxt = S_WAIT;
      end
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.Flush) state_nxt = S_FLUSH;
    pop = Rest && !bus.FifoEmpty && head_resolved && (state != S_FLUSH) && !bus.Flush &&
          (head_cancel || !dec_valid || bus.DecReady);
  end

  assign load = pop && !head_cancel;

  // Decode output register; a load on the accept edge replaces data with no bubble.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      dec_inst  <= '0;
      dec_excp  <= '0;
      dec_pred  <= 1'b0;
    end else if (bus.Flush) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid <= 1'b1;
      dec_pc    <= bus.FifoPreOut[FIFOWIDE-1 -: 32];
      dec_inst  <= bus.FifoPreOut[35:4];
      dec_excp  <= {bus.FifoPreOut[1], head_st == 2'b10};
      dec_pred  <= bus.FifoPreOut[0];
    end else if (dec_valid && bus.DecReady) begin
      dec_valid <= 1'b0;
    end
  end

  // Pending-head timer; saturates at the limit and snapshots the head pointer as it gets there.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wait_cnt <= '0;
      head_ptr <= '0;
    end else if (bus.Flush) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && state_nxt == S_WAIT) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 8'd1;
      if (wait_cnt == LIMIT - 8'd1) head_ptr <= bus.FifoPrePtr;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef ICFD_PERF_EN
  // Free-running event counters, wrapping, cleared only by reset.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      PerfPopCnt    <= '0;
      PerfCancelCnt <= '0;
      PerfStallCyc  <= '0;
    end else begin
      if (load)                PerfPopCnt    <= PerfPopCnt + 32'd1;
      if (pop && head_cancel)  PerfCancelCnt <= PerfCancelCnt + 32'd1;
      if (state == S_WAIT)     PerfStallCyc  <= PerfStallCyc + 32'd1;
    end
  end
`endif

  assign bus.Rable        = pop;
  assign bus.FifoClean    = (state == S_FLUSH);
  assign bus.DecValid     = dec_valid;
  assign bus.DecPc        = dec_pc;
  assign bus.DecInst      = dec_inst;
  assign bus.DecExcp      = dec_excp;
  assign bus.DecPredTaken = dec_pred;
  assign bus.HeadStall    = (wait_cnt == LIMIT);
  assign bus.HeadPtr      = head_ptr;

endmodule
